nanci_inject: RTL and testbench

Per-PE injection stage directly upstream of the PE sort logic in the `mesh` write network. It buffers host write requests (destination PE address plus data byte) in a small FIFO. On each network round it presents exactly one packet, or a null packet, to the PE, and holds it stable for the full `SORT_CYCLES` round so all PEs of the mesh stay in lockstep. One instance sits beside every PE; all instances share `round_start`.

---
 rtl/nanci_inject_pkg.sv | 15 +
 rtl/nanci_inject_if.sv | 32 +++
 rtl/nanci_fifo.sv | 49 ++++
 rtl/nanci_inject.sv | 111 +++++++++++
 tb/tb_nanci_inject.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/nanci_inject_pkg.sv
// Shared types and helpers for the nanci injection stage: packet width
// and the round FSM state encoding (IDLE=0, ROUND=1).
package nanci_inject_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ROUND = 1'b1
   } state_e;

   // A packet is {addr, data}; addr occupies the upper bits.
   function automatic int pkt_width(input int addr_width, input int data_width);
      return addr_width + data_width;
   endfunction

endpackage

// File: rtl/nanci_inject_if.sv
// Host-write and PE-facing signal bundle of one nanci_inject instance.
// master = host/mesh side, slave = the injection stage itself.
interface nanci_inject_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  round_start;
   logic                  pkt_valid;
   logic [ADDR_WIDTH-1:0] pkt_addr;
   logic [DATA_WIDTH-1:0] pkt_data;
   logic                  round_busy;
   logic                  round_done;
   logic [CNT_W-1:0]      count;

   modport master (
      output in_valid, in_addr, in_data, round_start,
      input  in_ready, pkt_valid, pkt_addr, pkt_data, round_busy, round_done, count
   );

   modport slave (
      input  in_valid, in_addr, in_data, round_start,
      output in_ready, pkt_valid, pkt_addr, pkt_data, round_busy, round_done, count
   );

endinterface

// File: rtl/nanci_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with registered occupancy count.
// Read data is the current head, valid whenever empty is low.
module nanci_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: storage has no reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/nanci_inject.sv
// Per-PE injection stage: buffers host writes and presents one packet (or a
// null packet) per mesh round, held stable for SORT_CYCLES cycles.
module nanci_inject
   import nanci_inject_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int SORT_CYCLES = 112,
   parameter int DEPTH       = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   nanci_inject_if.slave bus
);
   localparam int WIDTH = pkt_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int TMR_W = $clog2(SORT_CYCLES);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [TMR_W-1:0] LAST_CYCLE = TMR_W'(SORT_CYCLES - 1);

   state_e                state_q, state_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   logic                  pkt_valid_q, pkt_valid_d;
   logic [ADDR_WIDTH-1:0] pkt_addr_q, pkt_addr_d;
   logic [DATA_WIDTH-1:0] pkt_data_q, pkt_data_d;
   logic                  done_q, done_d;

   logic                  push, pop, full, empty;
   logic [WIDTH-1:0]      head;
   logic [CNT_W-1:0]      fifo_count;

   // Acceptance depends only on registered occupancy, never on a same-cycle pop.
   assign push = bus.in_valid && !full;

   nanci_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({bus.in_addr, bus.in_data}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      pkt_valid_d = pkt_valid_q;
      pkt_addr_d  = pkt_addr_q;
      pkt_data_d  = pkt_data_q;
      done_d      = 1'b0;
      pop         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.round_start) begin
               state_d     = ROUND;
               tmr_d       = '0;
               pop         = !empty;
               pkt_valid_d = !empty;
               pkt_addr_d  = empty ? '0 : head[WIDTH-1:DATA_WIDTH];
               pkt_data_d  = empty ? '0 : head[DATA_WIDTH-1:0];
            end
         end
         ROUND: begin
            // round_start is deliberately ignored here to keep all PEs in lockstep.
            if (tmr_q == LAST_CYCLE) begin
               state_d     = IDLE;
               tmr_d       = '0;
               pkt_valid_d = 1'b0;
               pkt_addr_d  = '0;
               pkt_data_d  = '0;
               done_d      = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         pkt_valid_q <= 1'b0;
         pkt_addr_q  <= '0;
         pkt_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_addr_q  <= pkt_addr_d;
         pkt_data_q  <= pkt_data_d;
         done_q      <= done_d;
      end
   end

   assign bus.in_ready   = !full;
   assign bus.count      = fifo_count;
   assign bus.pkt_valid  = pkt_valid_q;
   assign bus.pkt_addr   = pkt_addr_q;
   assign bus.pkt_data   = pkt_data_q;
   assign bus.round_busy = (state_q == ROUND);
   assign bus.round_done = done_q;

endmodule

// File: tb/tb_nanci_inject.sv
// Self-checking bench for nanci_inject: directed scenarios plus random traffic,
// compared each cycle against a queue-based round model.
module tb_nanci_inject;
   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int SC    = 112;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   nanci_inject_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   nanci_inject #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .SORT_CYCLES (SC),
      .DEPTH       (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model: a queue of pending writes and a round countdown.
   logic [AW+DW-1:0] q [$];
   bit               m_busy;
   int               m_left;
   logic             m_pv;
   logic [AW-1:0]    m_pa;
   logic [DW-1:0]    m_pd;
   logic             m_done;

   int n_checks = 0;
   int n_fail   = 0;
   int hi_cycles, busy_cycles, done_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_busy = 1'b0;
      m_left = 0;
      m_pv   = 1'b0;
      m_pa   = '0;
      m_pd   = '0;
      m_done = 1'b0;
   endtask

   task automatic check_all(input string ctx);
      check({ctx, ".pkt_valid"},  32'(bus.pkt_valid),  32'(m_pv));
      check({ctx, ".pkt_addr"},   32'(bus.pkt_addr),   32'(m_pa));
      check({ctx, ".pkt_data"},   32'(bus.pkt_data),   32'(m_pd));
      check({ctx, ".round_busy"}, 32'(bus.round_busy), 32'(m_busy));
      check({ctx, ".round_done"}, 32'(bus.round_done), 32'(m_done));
      check({ctx, ".count"},      32'(bus.count),      32'(q.size()));
      check({ctx, ".in_ready"},   32'(bus.in_ready),   32'(q.size() != DEPTH));
   endtask

   // Apply one cycle of inputs, advance the model across the edge, then compare.
   task automatic step(input string ctx, input logic v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rs);
      bit acc;
      bus.in_valid    = v;
      bus.in_addr     = a;
      bus.in_data     = d;
      bus.round_start = rs;
      acc = v && (q.size() < DEPTH);
      if (rst_n) begin
         m_done = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_pv   = 1'b0;
               m_pa   = '0;
               m_pd   = '0;
            end
         end else if (rs) begin
            m_busy = 1'b1;
            m_left = SC;
            if (q.size() > 0) begin
               {m_pa, m_pd} = q.pop_front();
               m_pv = 1'b1;
            end else begin
               m_pv = 1'b0;
               m_pa = '0;
               m_pd = '0;
            end
         end
         if (acc) q.push_back({a, d});
      end
      @(posedge clk);
      #1;
      check_all(ctx);
      if (bus.pkt_valid)  hi_cycles++;
      if (bus.round_busy) busy_cycles++;
      if (bus.round_done) done_cnt++;
   endtask

   task automatic idle(input string ctx, input int n);
      for (int i = 0; i < n; i++) step(ctx, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic clear_counters();
      hi_cycles   = 0;
      busy_cycles = 0;
      done_cnt    = 0;
   endtask

   initial begin
      int done_at;
      bus.in_valid    = 1'b0;
      bus.in_addr     = '0;
      bus.in_data     = '0;
      bus.round_start = 1'b0;
      model_reset();
      clear_counters();

      // Reset values.
      #1 rst_n = 1'b0;
      #1 check_all("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_all("reset_release");

      // Single push then a round carrying it.
      clear_counters();
      step("t1_push", 1'b1, 8'h2A, 8'h55, 1'b0);
      check("t1_count_after_push", 32'(bus.count), 32'd1);
      step("t1_start", 1'b0, '0, '0, 1'b1);
      check("t1_addr", 32'(bus.pkt_addr), 32'h2A);
      check("t1_data", 32'(bus.pkt_data), 32'h55);
      idle("t1_round", SC + 1);
      check("t1_valid_cycles", 32'(hi_cycles), 32'(SC));
      check("t1_done_pulses",  32'(done_cnt),  32'd1);

      // Null round with an empty FIFO.
      clear_counters();
      step("t2_start", 1'b0, '0, '0, 1'b1);
      idle("t2_round", SC + 1);
      check("t2_valid_cycles", 32'(hi_cycles),   32'd0);
      check("t2_busy_cycles",  32'(busy_cycles), 32'(SC));
      check("t2_done_pulses",  32'(done_cnt),    32'd1);

      // Fill the FIFO, a fifth write is refused, then four back-to-back rounds.
      for (int i = 0; i < 5; i++) step("t3_fill", 1'b1, AW'(i), DW'(8'hA0 + i), 1'b0);
      check("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
      check("t3_count_full",    32'(bus.count),    32'(DEPTH));
      for (int r = 0; r < 4; r++) begin
         step("t3_start", 1'b0, '0, '0, 1'b1);
         check("t3_order_addr", 32'(bus.pkt_addr), 32'(r));
         check("t3_order_data", 32'(bus.pkt_data), 32'(8'hA0 + r));
         idle("t3_round", SC);
      end
      idle("t3_tail", 1);
      check("t3_count_empty", 32'(bus.count), 32'd0);

      // Push coinciding with round_start on an empty FIFO.
      step("t4_push_start", 1'b1, 8'h77, 8'h88, 1'b1);
      check("t4_null_valid", 32'(bus.pkt_valid), 32'd0);
      check("t4_count",      32'(bus.count),     32'd1);
      idle("t4_round", SC);
      step("t4_start2", 1'b0, '0, '0, 1'b1);
      check("t4_second_addr", 32'(bus.pkt_addr), 32'h77);
      idle("t4_round2", SC);

      // round_start pulses mid-round are ignored.
      clear_counters();
      done_at = -1;
      step("t5_push", 1'b1, 8'h11, 8'h22, 1'b0);
      step("t5_start", 1'b0, '0, '0, 1'b1);
      for (int i = 1; i <= SC + 1; i++) begin
         step("t5_round", 1'b0, '0, '0, (i == 10) || (i == 50));
         if (bus.round_done) done_at = i;
      end
      check("t5_done_pulses", 32'(done_cnt), 32'd1);
      check("t5_done_at",     32'(done_at),  32'(SC));
      check("t5_valid_cycles", 32'(hi_cycles), 32'(SC));

      // Asynchronous reset mid-round aborts it without a round_done.
      step("t6_push", 1'b1, 8'h33, 8'h44, 1'b0);
      step("t6_push", 1'b1, 8'h35, 8'h46, 1'b0);
      step("t6_start", 1'b0, '0, '0, 1'b1);
      idle("t6_round", 39);
      #3 rst_n = 1'b0;
      model_reset();
      #1 check_all("t6_async_reset");
      step("t6_in_reset", 1'b1, 8'h01, 8'h02, 1'b1);
      step("t6_in_reset", 1'b1, 8'h01, 8'h02, 1'b1);
      rst_n = 1'b1;
      clear_counters();
      idle("t6_after", SC + 10);
      check("t6_no_done", 32'(done_cnt), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         step("rand", ($urandom_range(0, 3) == 0), AW'($urandom), DW'($urandom),
              ($urandom_range(0, 49) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
